dsp_result_serializer: RTL and testbench
========================================

Name: dsp_result_serializer

Overview:
- Output-side counterpart to the DSP48A1 operand input register stages: drains completed results (48-bit P plus CARRYOUT) out of the slice.
- Buffers results in a small FIFO.
- Emits each result as a 7-byte frame over a byte-wide valid/ready stream toward the host/UART bridge.
- Sits between the DSP48A1 P/CARRYOUT register outputs and the byte transport.

Parameters:
- FIFO_DEPTH, 4, result entries buffered; power of 2, minimum 2.
- HDR_NIBBLE, 4'hA, upper nibble of the frame header byte.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- flush  input  1  synchronous: empty FIFO and abort the current frame
- in_valid  input  1  result word present on p_in/cout_in
- in_ready  output  1  block can accept a result this cycle
- p_in  input  48  DSP48A1 P result
- cout_in  input  1  DSP48A1 CARRYOUT accompanying p_in
- tx_data  output  8  frame byte
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  downstream accepts byte
- tx_last  output  1  marks final byte (byte 6) of a frame
- busy  output  1  FIFO non-empty or frame in progress

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk.
  - Asserting rst immediately clears the FIFO pointers and count, the FSM (to IDLE), the byte index and the shift register.
  - Output values during and after reset: tx_valid=0, tx_data=8'h00, tx_last=0, busy=0, in_ready=1.
  - Reset mid-frame drops the frame with no further bytes emitted; downstream must tolerate a truncated frame on reset.
- Input side:
  - Push occurs when in_valid && in_ready at a clk edge; the stored entry is {cout_in, p_in} (49 bits).
  - in_ready = !full, a combinational decode of a registered count. No pass-through when full: a simultaneous pop does not raise in_ready in that same cycle.
  - in_valid while !in_ready is ignored (no push, no error).
- Frame format, bytes in order:
  - byte0 = {HDR_NIBBLE, 3'b000, cout}
  - byte1 = P[7:0], byte2 = P[15:8] ... byte6 = P[47:40] (little-endian)
- FSM states: IDLE, SEND.
  - IDLE: if FIFO non-empty, pop the head into the 49-bit shift register, set idx=0, go to SEND. tx_valid=0 in IDLE.
  - SEND: tx_valid=1, tx_data=byte[idx], tx_last=(idx==6).
    - On a tx_valid && tx_ready edge with idx<6: idx increments.
    - On an accepted byte with idx==6: if the FIFO is non-empty, pop the next entry in the same edge and stay in SEND with idx=0 (zero-bubble back-to-back frames); else go to IDLE.
  - While tx_valid && !tx_ready, tx_data and tx_last are held stable.
- Latency: a push at edge k into an empty FIFO with FSM in IDLE gives tx_valid=1 with byte0 after edge k+1. Throughput is 1 byte/cycle with tx_ready held high.
- Simultaneous push and pop in one edge: count unchanged; both operations take effect.
- Pointers: log2(FIFO_DEPTH) bits, wrap naturally. count is log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
- flush: at the edge where flush=1:
  - FIFO is emptied; FSM goes to IDLE; tx_valid=0 after that edge, even mid-frame.
  - flush has priority over a push in the same cycle; that word is discarded.
- busy = (state==SEND) || (count!=0).
- Cycle-accurate; no combinational path from tx_ready to tx_valid or tx_data.

Test Plan:
- Single frame: push p_in=48'h0123_4567_89AB, cout_in=1, tx_ready=1 -> after the push edge+1, bytes A1,AB,89,67,45,23,01 on 7 consecutive cycles; tx_last only on 01; busy falls the cycle after the last byte.
- Back-to-back: push 3 words on consecutive cycles, tx_ready=1 -> 21 contiguous bytes, tx_valid never drops, tx_last at bytes 7, 14, 21.
- Backpressure: during a frame drive tx_ready=0 for 5 cycles at idx=3 -> tx_data holds byte3 and tx_last=0 throughout; the stream resumes with byte3 accepted, no byte lost or duplicated.
- Full FIFO: tx_ready=0, push 6 words -> 1 moves to the shift register, 4 fill the FIFO, in_ready=0, word 6 is not accepted; release tx_ready -> exactly 5 frames out, in order.
- Flush mid-frame: flush=1 at idx=2 with 2 words queued and in_valid=1 -> tx_valid=0 next cycle, busy=0, count=0; the concurrent word is not stored.
- Async reset: assert rst between clock edges mid-frame -> tx_valid, tx_last and tx_data drop to 0 immediately (before the next edge); in_ready=1 after release; the next push produces a fresh frame starting at byte0.

Source files
------------

// File: rtl/dsp_result_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_result_serializer
//  Purpose  : Drains DSP48A1 results (48-bit P plus CARRYOUT) through a small
//             FIFO and emits each one as a 7-byte frame on a byte-wide
//             valid/ready stream toward the host/UART bridge.
//
//             Frame layout, in transmit order:
//               byte0 = {HDR_NIBBLE, 3'b000, carryout}
//               byte1 = P[7:0]  ...  byte6 = P[47:40]   (little-endian)
//
//  Ports    : clk       - clock, all logic on the rising edge
//             rst       - asynchronous active-high reset
//             flush     - synchronous: empty FIFO and abort current frame
//             in_valid  - result word present on p_in / cout_in
//             in_ready  - block can accept a result this cycle
//             p_in      - DSP48A1 P result (48 bits)
//             cout_in   - DSP48A1 CARRYOUT accompanying p_in
//             tx_data   - frame byte
//             tx_valid  - tx_data valid
//             tx_ready  - downstream accepts byte
//             tx_last   - marks final byte (byte 6) of a frame
//             busy      - FIFO non-empty or frame in progress
//
//  Revision : 1.0 - initial release
// ============================================================================
module dsp_result_serializer #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] HDR_NIBBLE = 4'hA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] p_in,
  input  logic        cout_in,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] C_FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0] C_PTR_ONE    = PTR_W'(1);
  localparam logic [2:0]       C_LAST_IDX   = 3'd6;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [48:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [0:0]       r_state;
  logic [2:0]       r_idx;
  // Bit 48 holds the carry for the header byte; bits 47:0 are shifted right
  // by one byte after each payload byte so the current byte is always [7:0].
  logic [48:0]      r_shreg;

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic        w_fifo_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_tx_accept;
  logic        w_frame_done;
  logic [48:0] w_head;

  assign w_fifo_empty = (r_count == '0);
  assign w_head       = r_mem[r_rd_ptr];

  // in_ready depends only on the registered count, so a pop in the same
  // cycle never opens the input while the FIFO is full.
  assign in_ready     = (r_count != C_FULL_COUNT);

  assign w_tx_accept  = (r_state == S_SEND) && tx_ready;
  assign w_frame_done = w_tx_accept && (r_idx == C_LAST_IDX);

  // flush outranks both sides: the concurrent input word is dropped and no
  // entry leaves the FIFO on that edge.
  assign w_push = in_valid && in_ready && !flush;
  assign w_pop  = !flush && !w_fifo_empty &&
                  ((r_state == S_IDLE) || w_frame_done);

  // --------------------------------------------------------------------------
  // FIFO storage (data only, no reset needed: validity tracked by count)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cout_in, p_in};
    end
  end

  // --------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Frame sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= 3'd0;
      r_shreg <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_idx   <= 3'd0;
      r_shreg <= '0;
    end else if (w_pop) begin
      // Covers both the IDLE start and the zero-bubble reload after byte 6.
      r_state <= S_SEND;
      r_idx   <= 3'd0;
      r_shreg <= w_head;
    end else if (w_frame_done) begin
      r_state <= S_IDLE;
      r_idx   <= 3'd0;
    end else if (w_tx_accept) begin
      r_idx <= r_idx + 3'd1;
      // The header byte does not consume payload; every payload byte does.
      if (r_idx != 3'd0) begin
        r_shreg[47:0] <= {8'h00, r_shreg[47:8]};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (registered state only; tx_ready never reaches these)
  // --------------------------------------------------------------------------
  always_comb begin
    tx_data = 8'h00;
    if (r_state == S_SEND) begin
      if (r_idx == 3'd0) begin
        tx_data = {HDR_NIBBLE, 3'b000, r_shreg[48]};
      end else begin
        tx_data = r_shreg[7:0];
      end
    end
  end

  assign tx_valid = (r_state == S_SEND);
  assign tx_last  = (r_state == S_SEND) && (r_idx == C_LAST_IDX);
  assign busy     = (r_state == S_SEND) || !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_dsp_result_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dsp_result_serializer
//  Purpose  : Self-checking bench for dsp_result_serializer. Expected frame
//             bytes come from a byte-queue reference model built from the
//             frame format; occupancy is derived from words pushed versus
//             frames started on the output stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_result_serializer;

  localparam int         DEPTH = 4;
  localparam logic [3:0] HDR   = 4'hA;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] p_in = '0;
  logic        cout_in = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tx_last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  dsp_result_serializer #(
    .FIFO_DEPTH (DEPTH),
    .HDR_NIBBLE (HDR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .p_in     (p_in),
    .cout_in  (cout_in),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_last  (tx_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: frame byte i of a 49-bit {cout, P} word.
  function automatic logic [7:0] exp_byte(input logic [48:0] w, input int i);
    logic [47:0] p;
    p = w[47:0];
    if (i == 0) return {HDR, 3'b000, w[48]};
    return 8'((p >> (8 * (i - 1))) & 48'hFF);
  endfunction

  function automatic logic [48:0] rand_word();
    return {1'($urandom), 16'($urandom), 32'($urandom)};
  endfunction

  task automatic apply_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    tx_ready = 1'b0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Leaves the caller at a negedge where tx_valid is high, or reports a timeout.
  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (tx_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: tx_valid never rose (got 0, want 1)", name);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    tx_ready = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    checks++; if (tx_last !== 1'b0) begin errors++; $display("FAIL reset_tx_last: got %b want 0", tx_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if ({tx_valid, busy, in_ready} !== 3'b001) begin errors++; $display("FAIL post_reset_outputs: got %b want 001", {tx_valid, busy, in_ready}); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_single_frame();
    logic [48:0] w;
    logic [7:0]  lit [7];
    apply_reset();
    w = {1'b1, 48'h0123_4567_89AB};
    lit = '{8'hA1, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    tx_ready = 1'b1;
    in_valid = 1'b1; {cout_in, p_in} = w;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++; if ({tx_valid, busy} !== 2'b01) begin errors++; $display("FAIL single_latency: valid,busy got %b want 01", {tx_valid, busy}); end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if ({tx_valid, tx_last, tx_data} !== {1'b1, (i == 6), lit[i]} || lit[i] !== exp_byte(w, i)) begin
        errors++;
        $display("FAIL single_byte%0d: valid,last,data got %b,%b,%h want 1,%b,%h", i, tx_valid, tx_last, tx_data, (i == 6), lit[i]);
      end
    end
    @(negedge clk);
    checks++; if ({tx_valid, busy} !== 2'b00) begin errors++; $display("FAIL single_end: valid,busy got %b want 00", {tx_valid, busy}); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [48:0] w [3];
    bit ok;
    apply_reset();
    foreach (w[j]) w[j] = rand_word();
    tx_ready = 1'b1;
    fork
      begin
        for (int j = 0; j < 3; j++) begin
          in_valid = 1'b1; {cout_in, p_in} = w[j];
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        wait_valid("b2b_start", ok);
        if (ok) begin
          for (int n = 0; n < 21; n++) begin
            if (n > 0) @(negedge clk);
            checks++;
            if ({tx_valid, tx_last, tx_data} !== {1'b1, (n % 7 == 6), exp_byte(w[n / 7], n % 7)}) begin
              errors++;
              $display("FAIL b2b_byte%0d: valid,last,data got %b,%b,%h want 1,%b,%h", n, tx_valid, tx_last, tx_data, (n % 7 == 6), exp_byte(w[n / 7], n % 7));
            end
          end
          @(negedge clk);
          checks++; if ({tx_valid, busy} !== 2'b00) begin errors++; $display("FAIL b2b_end: valid,busy got %b want 00", {tx_valid, busy}); end
        end
      end
    join
  endtask

  // --------------------------------------------------------------------------
  task automatic test_backpressure();
    logic [48:0] w;
    bit ok;
    apply_reset();
    w = rand_word();
    tx_ready = 1'b1;
    in_valid = 1'b1; {cout_in, p_in} = w;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_valid("bp_start", ok);
    if (ok) begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if ({tx_valid, tx_last, tx_data} !== {1'b1, (i == 6), exp_byte(w, i)}) begin
          errors++;
          $display("FAIL bp_byte%0d: valid,last,data got %b,%b,%h want 1,%b,%h", i, tx_valid, tx_last, tx_data, (i == 6), exp_byte(w, i));
        end
        if (i == 2) begin
          @(posedge clk); #1 tx_ready = 1'b0;
          for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            checks++;
            if ({tx_valid, tx_last, tx_data} !== {2'b10, exp_byte(w, 3)}) begin
              errors++;
              $display("FAIL bp_hold%0d: valid,last,data got %b,%b,%h want 1,0,%h", s, tx_valid, tx_last, tx_data, exp_byte(w, 3));
            end
            @(posedge clk);
          end
          #1 tx_ready = 1'b1;
          @(negedge clk);
        end else begin
          @(negedge clk);
        end
      end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL bp_end: tx_valid got %b want 0", tx_valid); end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_full_fifo();
    logic [48:0] w [6];
    apply_reset();
    foreach (w[j]) w[j] = rand_word();
    tx_ready = 1'b0;
    for (int j = 0; j < 6; j++) begin
      in_valid = 1'b1; {cout_in, p_in} = w[j];
      @(negedge clk);
      checks++;
      if (in_ready !== (j < 5)) begin
        errors++;
        $display("FAIL full_in_ready_w%0d: got %b want %b", j, in_ready, (j < 5));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if ({in_ready, busy} !== 2'b01) begin errors++; $display("FAIL full_hold: in_ready,busy got %b want 01", {in_ready, busy}); end
    @(posedge clk); #1 tx_ready = 1'b1;
    for (int n = 0; n < 35; n++) begin
      @(negedge clk);
      checks++;
      if ({tx_valid, tx_last, tx_data} !== {1'b1, (n % 7 == 6), exp_byte(w[n / 7], n % 7)}) begin
        errors++;
        $display("FAIL full_byte%0d: valid,last,data got %b,%b,%h want 1,%b,%h", n, tx_valid, tx_last, tx_data, (n % 7 == 6), exp_byte(w[n / 7], n % 7));
      end
    end
    @(negedge clk);
    checks++; if ({tx_valid, busy} !== 2'b00) begin errors++; $display("FAIL full_end (6th word leaked?): valid,busy got %b want 00", {tx_valid, busy}); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_flush();
    logic [48:0] w [3];
    int seen;
    apply_reset();
    foreach (w[j]) w[j] = rand_word();
    tx_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1; {cout_in, p_in} = w[j];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({tx_valid, tx_data} !== {1'b1, exp_byte(w[0], i)}) begin
        errors++;
        $display("FAIL flush_pre_byte%0d: valid,data got %b,%h want 1,%h", i, tx_valid, tx_data, exp_byte(w[0], i));
      end
      @(posedge clk); #1;
    end
    flush = 1'b1; in_valid = 1'b1; {cout_in, p_in} = rand_word(); tx_ready = 1'b0;
    @(negedge clk);
    checks++; if ({tx_valid, tx_data} !== {1'b1, exp_byte(w[0], 2)}) begin errors++; $display("FAIL flush_idx2: valid,data got %b,%h want 1,%h", tx_valid, tx_data, exp_byte(w[0], 2)); end
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0; tx_ready = 1'b1;
    @(negedge clk);
    checks++; if ({tx_valid, tx_last, busy, in_ready} !== 4'b0001) begin errors++; $display("FAIL flush_after: valid,last,busy,in_ready got %b want 0001", {tx_valid, tx_last, busy, in_ready}); end
    seen = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (tx_valid || busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_quiet: active cycles got %0d want 0", seen); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_async_reset();
    logic [48:0] w;
    bit ok;
    apply_reset();
    w = rand_word();
    tx_ready = 1'b1;
    in_valid = 1'b1; {cout_in, p_in} = w;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_valid("areset_start", ok);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({tx_valid, tx_last, tx_data} !== 10'b0) begin errors++; $display("FAIL areset_immediate: valid,last,data got %b,%b,%h want 0,0,00", tx_valid, tx_last, tx_data); end
    checks++; if ({busy, in_ready} !== 2'b01) begin errors++; $display("FAIL areset_busy_ready: got %b want 01", {busy, in_ready}); end
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checks++; if ({tx_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL areset_release: valid,in_ready got %b want 01", {tx_valid, in_ready}); end
    w = rand_word();
    @(posedge clk); #1 in_valid = 1'b1; {cout_in, p_in} = w;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_valid("areset_fresh", ok);
    if (ok) begin
      for (int i = 0; i < 7; i++) begin
        if (i > 0) @(negedge clk);
        checks++;
        if ({tx_valid, tx_last, tx_data} !== {1'b1, (i == 6), exp_byte(w, i)}) begin
          errors++;
          $display("FAIL areset_fresh_byte%0d: valid,last,data got %b,%b,%h want 1,%b,%h", i, tx_valid, tx_last, tx_data, (i == 6), exp_byte(w, i));
        end
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_random();
    logic [8:0] exp_q [$];
    logic [48:0] w;
    logic [9:0] prev;
    bit prev_stall;
    int pushed, acc_bytes, started, cnt;
    apply_reset();
    pushed = 0; acc_bytes = 0; prev_stall = 1'b0; prev = '0;
    for (int c = 0; c < 560; c++) begin
      if (c < 500) begin
        in_valid = 1'($urandom);
        tx_ready = ($urandom_range(9) < 6);
      end else begin
        in_valid = 1'b0;
        tx_ready = 1'b1;
      end
      w = rand_word();
      {cout_in, p_in} = w;
      @(negedge clk);
      started = acc_bytes / 7 + (tx_valid ? 1 : 0);
      cnt = pushed - started;
      checks++;
      if (in_ready !== (cnt < DEPTH)) begin
        errors++;
        $display("FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready, (cnt < DEPTH));
      end
      checks++;
      if (busy !== (tx_valid || cnt != 0)) begin
        errors++;
        $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, (tx_valid || cnt != 0));
      end
      if (prev_stall) begin
        checks++;
        if ({tx_valid, tx_last, tx_data} !== prev) begin
          errors++;
          $display("FAIL rnd_hold c%0d: got %h want %h", c, {tx_valid, tx_last, tx_data}, prev);
        end
      end
      if (tx_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rnd_unexpected c%0d: got byte %h want none", c, tx_data);
        end else if ({tx_last, tx_data} !== exp_q[0]) begin
          errors++;
          $display("FAIL rnd_byte c%0d: last,data got %b,%h want %b,%h", c, tx_last, tx_data, exp_q[0][8], exp_q[0][7:0]);
        end
        if (tx_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          acc_bytes++;
        end
      end
      if (in_valid && in_ready) begin
        for (int i = 0; i < 7; i++) exp_q.push_back({(i == 6), exp_byte(w, i)});
        pushed++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev = {tx_valid, tx_last, tx_data};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rnd_drain: pending bytes got %0d busy %b want 0 busy 0", exp_q.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_full_fifo();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
